// File: rtl/div_sched.sv
// Two-requester scheduler for a shared multi-cycle divider.
// Round-robin grant, clear/run sequencing and a held response.
module div_sched #(
    parameter int C_NUM_BITS = 24,
    parameter int C_LAT      = 26
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  REQ0_V,
    input  logic [C_NUM_BITS-1:0] REQ0_A,
    input  logic [C_NUM_BITS-1:0] REQ0_B,
    output logic                  REQ0_RDY,
    input  logic                  REQ1_V,
    input  logic [C_NUM_BITS-1:0] REQ1_A,
    input  logic [C_NUM_BITS-1:0] REQ1_B,
    output logic                  REQ1_RDY,
    output logic                  RSP_V,
    input  logic                  RSP_RDY,
    output logic                  RSP_ID,
    output logic [C_NUM_BITS-1:0] RSP_Q,
    output logic                  RSP_DZ,
    output logic                  DIV_E,
    output logic                  DIV_CLRN,
    output logic [C_NUM_BITS-1:0] DIV_A,
    output logic [C_NUM_BITS-1:0] DIV_B,
    input  logic [C_NUM_BITS-1:0] DIV_Q,
    output logic                  BUSY
);

    localparam int CW = (C_LAT > 1) ? $clog2(C_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(C_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic                  ptr;
    logic [CW-1:0]         cnt;
    logic [C_NUM_BITS-1:0] a_r;
    logic [C_NUM_BITS-1:0] b_r;
    logic [C_NUM_BITS-1:0] q_r;
    logic                  id_r;
    logic                  dz_r;

    logic                  gnt0;
    logic                  gnt1;
    logic                  hs;
    logic                  hs_id;
    logic [C_NUM_BITS-1:0] sel_a;
    logic [C_NUM_BITS-1:0] sel_b;
    logic                  sel_zero;

    // On a tie the pointer names the last winner, so the other side wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RN && state == IDLE) begin
            if (REQ0_V && REQ1_V) begin
                gnt0 = ptr;
                gnt1 = ~ptr;
            end else begin
                gnt0 = REQ0_V;
                gnt1 = REQ1_V;
            end
        end
    end

    assign REQ0_RDY = gnt0;
    assign REQ1_RDY = gnt1;
    assign hs       = gnt0 | gnt1;
    assign hs_id    = gnt1;
    assign sel_a    = hs_id ? REQ1_A : REQ0_A;
    assign sel_b    = hs_id ? REQ1_B : REQ0_B;
    assign sel_zero = (sel_b == '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    state_nx = sel_zero ? DONE : CLR;
                end
            end
            CLR: state_nx = RUN;
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (RSP_RDY) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state <= IDLE;
            ptr   <= 1'b1;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            q_r   <= '0;
            id_r  <= 1'b0;
            dz_r  <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs) begin
                a_r  <= sel_a;
                b_r  <= sel_b;
                id_r <= hs_id;
                ptr  <= hs_id;
                if (sel_zero) begin
                    q_r  <= '1;
                    dz_r <= 1'b1;
                end
            end
            if (state == RUN) begin
                if (cnt == LAST) begin
                    cnt  <= '0;
                    q_r  <= DIV_Q;
                    dz_r <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign BUSY     = (state != IDLE);
    assign RSP_V    = (state == DONE);
    assign RSP_ID   = id_r;
    assign RSP_Q    = q_r;
    assign RSP_DZ   = dz_r;
    assign DIV_A    = a_r;
    assign DIV_B    = b_r;
    // Divider controls are forced inactive/cleared while reset is held.
    assign DIV_E    = RN & ((state == CLR) | (state == RUN));
    assign DIV_CLRN = RN & (state != CLR);

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a latency-accurate divider model.
// Expected values are hand-computed constants.
module tb_div_sched;

    localparam int N   = 24;
    localparam int LAT = 26;

    logic         CK = 1'b0;
    logic         RN = 1'b0;
    logic         REQ0_V = 1'b0;
    logic [N-1:0] REQ0_A = '0;
    logic [N-1:0] REQ0_B = '0;
    logic         REQ0_RDY;
    logic         REQ1_V = 1'b0;
    logic [N-1:0] REQ1_A = '0;
    logic [N-1:0] REQ1_B = '0;
    logic         REQ1_RDY;
    logic         RSP_V;
    logic         RSP_RDY = 1'b0;
    logic         RSP_ID;
    logic [N-1:0] RSP_Q;
    logic         RSP_DZ;
    logic         DIV_E;
    logic         DIV_CLRN;
    logic [N-1:0] DIV_A;
    logic [N-1:0] DIV_B;
    logic [N-1:0] DIV_Q;
    logic         BUSY;

    int n_chk = 0;
    int n_err = 0;
    int mcnt  = 0;
    int bad;

    always #5 CK = ~CK;

    div_sched #(.C_NUM_BITS(N), .C_LAT(LAT)) dut (
        .CK(CK), .RN(RN),
        .REQ0_V(REQ0_V), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
        .REQ0_RDY(REQ0_RDY),
        .REQ1_V(REQ1_V), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .REQ1_RDY(REQ1_RDY),
        .RSP_V(RSP_V), .RSP_RDY(RSP_RDY), .RSP_ID(RSP_ID),
        .RSP_Q(RSP_Q), .RSP_DZ(RSP_DZ),
        .DIV_E(DIV_E), .DIV_CLRN(DIV_CLRN),
        .DIV_A(DIV_A), .DIV_B(DIV_B), .DIV_Q(DIV_Q),
        .BUSY(BUSY)
    );

    // Divider model: quotient valid only LAT enabled cycles after clear.
    always @(posedge CK) begin
        if (DIV_E && !DIV_CLRN) mcnt <= 0;
        else if (DIV_E) mcnt <= mcnt + 1;
    end

    assign DIV_Q = (DIV_E && DIV_CLRN && mcnt == LAT - 1 && DIV_B != 0)
                   ? DIV_A / DIV_B : 24'h5A5A5A;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CK);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, request pending while reset held
        RN = 1'b0;
        REQ0_V = 1'b1;
        step(3);
        chk("rst_busy", BUSY, 0);
        chk("rst_rsp_v", RSP_V, 0);
        chk("rst_q", RSP_Q, 0);
        chk("rst_id", RSP_ID, 0);
        chk("rst_dz", RSP_DZ, 0);
        chk("rst_div_e", DIV_E, 0);
        chk("rst_clrn", DIV_CLRN, 0);
        chk("rst_rdy0", REQ0_RDY, 0);
        RN = 1'b1;
        REQ0_V = 1'b0;
        step(1);
        chk("idle_clrn", DIV_CLRN, 1);
        chk("idle_busy", BUSY, 0);

        // 100 / 7 with response held for 10 cycles
        REQ0_V = 1'b1; REQ0_A = 100; REQ0_B = 7;
        #1;
        chk("hs_rdy0", REQ0_RDY, 1);
        chk("hs_rdy1", REQ1_RDY, 0);
        step(1);
        REQ0_V = 1'b0;
        #1;
        chk("clr_clrn", DIV_CLRN, 0);
        chk("clr_e", DIV_E, 1);
        chk("clr_busy", BUSY, 1);
        chk("clr_a", DIV_A, 100);
        chk("clr_b", DIV_B, 7);
        bad = 0;
        for (int i = 2; i <= 27; i++) begin
            step(1);
            if (RSP_V !== 1'b0 || DIV_E !== 1'b1 || DIV_CLRN !== 1'b1
                || DIV_A !== 24'd100 || DIV_B !== 24'd7) bad++;
        end
        chk("run_window", bad, 0);
        step(1);
        chk("t28_v", RSP_V, 1);
        chk("t28_id", RSP_ID, 0);
        chk("t28_q", RSP_Q, 14);
        chk("t28_dz", RSP_DZ, 0);
        chk("t28_e", DIV_E, 0);
        REQ0_V = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (RSP_V !== 1'b1 || RSP_Q !== 24'd14 || RSP_ID !== 1'b0
                || RSP_DZ !== 1'b0 || REQ0_RDY !== 1'b0
                || BUSY !== 1'b1 || DIV_E !== 1'b0) bad++;
            step(1);
        end
        chk("hold_stable", bad, 0);
        RSP_RDY = 1'b1;
        #1;
        chk("retire_rdy0", REQ0_RDY, 0);
        chk("retire_v", RSP_V, 1);
        step(1);
        chk("post_v", RSP_V, 0);
        chk("post_busy", BUSY, 0);
        chk("post_rdy0", REQ0_RDY, 1);
        REQ0_V = 1'b0;

        // Round-robin after reset
        RN = 1'b0;
        step(1);
        RN = 1'b1;
        REQ0_V = 1'b1; REQ0_A = 50; REQ0_B = 5;
        REQ1_V = 1'b1; REQ1_A = 81; REQ1_B = 9;
        RSP_RDY = 1'b1;
        #1;
        chk("rr1_rdy0", REQ0_RDY, 1);
        chk("rr1_rdy1", REQ1_RDY, 0);
        step(1);
        chk("rr1_busy_rdy1", REQ1_RDY, 0);
        step(27);
        chk("rr1_v", RSP_V, 1);
        chk("rr1_id", RSP_ID, 0);
        chk("rr1_q", RSP_Q, 10);
        step(1);
        chk("rr2_rdy1", REQ1_RDY, 1);
        chk("rr2_rdy0", REQ0_RDY, 0);
        step(28);
        chk("rr2_v", RSP_V, 1);
        chk("rr2_id", RSP_ID, 1);
        chk("rr2_q", RSP_Q, 9);
        step(1);
        chk("rr3_rdy0", REQ0_RDY, 1);
        chk("rr3_rdy1", REQ1_RDY, 0);
        REQ0_V = 1'b0;
        REQ1_V = 1'b0;
        step(1);

        // Divide by zero on requester 1
        RSP_RDY = 1'b0;
        REQ1_V = 1'b1; REQ1_A = 123; REQ1_B = 0;
        #1;
        chk("dz_rdy1", REQ1_RDY, 1);
        chk("dz_e0", DIV_E, 0);
        step(1);
        REQ1_V = 1'b0;
        chk("dz_v", RSP_V, 1);
        chk("dz_q", RSP_Q, 24'hFFFFFF);
        chk("dz_flag", RSP_DZ, 1);
        chk("dz_id", RSP_ID, 1);
        chk("dz_e1", DIV_E, 0);
        RSP_RDY = 1'b1;
        step(1);
        chk("dz_post_v", RSP_V, 0);
        chk("dz_post_e", DIV_E, 0);

        // Reset in the middle of RUN
        REQ0_V = 1'b1; REQ0_A = 200; REQ0_B = 3;
        #1;
        chk("ab_rdy0", REQ0_RDY, 1);
        step(1);
        REQ0_V = 1'b0;
        step(9);
        chk("ab_run_e", DIV_E, 1);
        RN = 1'b0;
        step(1);
        REQ0_V = 1'b1;
        #1;
        chk("ab_busy", BUSY, 0);
        chk("ab_v", RSP_V, 0);
        chk("ab_e", DIV_E, 0);
        chk("ab_clrn", DIV_CLRN, 0);
        chk("ab_rdy0", REQ0_RDY, 0);
        RN = 1'b1;
        REQ0_V = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (RSP_V !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        chk("ab_no_rsp", bad, 0);

        // Full-scale dividend, divisor 1
        REQ0_V = 1'b1; REQ0_A = 24'hFFFFFF; REQ0_B = 1;
        #1;
        chk("max_rdy0", REQ0_RDY, 1);
        step(1);
        REQ0_V = 1'b0;
        step(27);
        chk("max_v", RSP_V, 1);
        chk("max_q", RSP_Q, 24'hFFFFFF);
        chk("max_dz", RSP_DZ, 0);
        step(1);
        chk("max_post_busy", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter C_NUM_BITS, default 24, operand/quotient width; SHALL match the shared divider width.
REQ-002 Parameter C_LAT, default 26, divider cycles from clear release to valid quotient; SHALL be >= 2.
REQ-003 CK  input  1  clock; all state SHALL update on rising edge only.
REQ-004 RN  input  1  reset; synchronous, active-low.
REQ-005 REQ0_V / REQ1_V  input  1 each  requester 0/1 has an operation pending.
REQ-006 REQ0_A, REQ0_B / REQ1_A, REQ1_B  input  C_NUM_BITS each  dividend, divisor per requester.
REQ-007 REQ0_RDY / REQ1_RDY  output  1 each  request accepted this cycle.
REQ-008 RSP_V  output  1  response valid.
REQ-009 RSP_RDY  input  1  consumer accepts response.
REQ-010 RSP_ID  output  1  requester index of response.
REQ-011 RSP_Q  output  C_NUM_BITS  quotient.
REQ-012 RSP_DZ  output  1  divide-by-zero flag.
REQ-013 DIV_E  output  1  divider clock-gate enable.
REQ-014 DIV_CLRN  output  1  divider local clear, active-low.
REQ-015 DIV_A, DIV_B  output  C_NUM_BITS each  operands to divider.
REQ-016 DIV_Q  input  C_NUM_BITS  divider quotient.
REQ-017 BUSY  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, CLR, RUN, DONE; one-hot or binary is free.
REQ-019 In IDLE, grant SHALL go to the single valid requester; if both valid, to the one not granted last (round-robin pointer).
REQ-020 REQx_RDY SHALL be high only in IDLE and only for the granted requester, combinationally from REQx_V and pointer; never both high.
REQ-021 On handshake (REQx_V & REQx_RDY at edge t), A, B, ID SHALL be captured and the pointer SHALL record x.
REQ-022 If captured B == 0: next state DONE at t+1, RSP_Q all ones, RSP_DZ=1, DIV_E stays 0.
REQ-023 Else next state CLR: one cycle with DIV_CLRN=0, DIV_E=1.
REQ-024 RUN: DIV_CLRN=1, DIV_E=1, internal counter 0..C_LAT-1; at count C_LAT-1, DIV_Q SHALL be captured into RSP_Q, RSP_DZ=0, next state DONE.
REQ-025 Timing: CLR in cycle t+1, RUN t+2..t+1+C_LAT, RSP_V first high in cycle t+2+C_LAT (default t+28).
REQ-026 DIV_A/DIV_B SHALL equal captured operands and stay stable from CLR through RUN; DIV_E=0 in IDLE and DONE.
REQ-027 DONE: RSP_V=1; RSP_ID, RSP_Q, RSP_DZ SHALL hold stable until RSP_V & RSP_RDY at an edge, then next state IDLE.
REQ-028 A new request SHALL NOT be accepted in the cycle the response retires; earliest next handshake is the following cycle (IDLE).
REQ-029 Requests arriving or dropping while not in IDLE SHALL be ignored; REQx_V may deassert without penalty.
REQ-030 Counter SHALL be ceil(log2(C_LAT)) bits minimum and SHALL NOT wrap during RUN.

Reset
REQ-031 With RN low at an edge: state IDLE, pointer = 1 (so requester 0 wins first tie), counter 0, RSP_V=0, RSP_Q=0, RSP_ID=0, RSP_DZ=0, DIV_E=0, DIV_CLRN=0, BUSY=0.
REQ-032 Reset in any state SHALL abort the operation with no response issued; REQx_RDY SHALL be 0 while RN is low.
REQ-033 DIV_CLRN SHALL be 1 in IDLE after reset release.

Verification
REQ-034 REQ0: A=100, B=7 handshake at t -> RSP_V high at t+28, RSP_ID=0, RSP_Q=14, RSP_DZ=0; DIV_CLRN=0 only at t+1.
REQ-035 Both valid after reset (REQ0 A=50,B=5; REQ1 A=81,B=9), RSP_RDY=1 -> REQ0 served first (Q=10), then REQ1 (Q=9); then REQ0 again if both remain valid.
REQ-036 REQ1: A=123, B=0 -> RSP_V at t+1, RSP_Q=0xFFFFFF, RSP_DZ=1, DIV_E never high.
REQ-037 RSP_RDY held low 10 cycles in DONE -> RSP_* stable, REQx_RDY=0, BUSY=1; release -> IDLE next cycle.
REQ-038 RN low during RUN (cycle t+10) -> next cycle IDLE, RSP_V never asserted, DIV_E=0, DIV_CLRN=0.
REQ-039 A=0xFFFFFF, B=1 -> RSP_Q=0xFFFFFF, RSP_DZ=0.
